// File: rtl/dsm_bitstream_gen_if.sv
// Word-input handshake for the delta-sigma bitstream generator.
// A word transfers on a rising clk edge where data_valid && data_ready; the source holds data_in stable while data_valid is high, and data_ready is registered.
interface dsm_bitstream_gen_if #(
  parameter int DATA_W = 12
) ();
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/dsm_bitstream_gen.sv
// Second-order delta-sigma modulator: one unsigned word per OSR-bit frame in, one bit per clk out.
// Each word is held for a full frame through a 1-entry holding register.
module dsm_bitstream_gen #(
  parameter int DATA_W = 12,
  parameter int OSR    = 512,
  parameter int I1_W   = 16,
  parameter int I2_W   = 18
) (
  input  logic                clk,
  input  logic                rst,
  dsm_bitstream_gen_if.slave  sif,
  output logic                bit_out,
  output logic                frame_start,
  output logic                underrun
);
  localparam int CNT_W = $clog2(OSR);
  localparam int S1_W  = I1_W + 2;
  localparam int S2_W  = I2_W + 2;

  localparam logic [DATA_W-1:0] MID      = DATA_W'(2 ** (DATA_W - 1));
  localparam logic [DATA_W:0]   HALF     = (DATA_W + 1)'(2 ** (DATA_W - 1));
  localparam logic [DATA_W:0]   NEG_HALF = (DATA_W + 1)'(-(2 ** (DATA_W - 1)));

  logic [CNT_W-1:0]  cnt;
  logic              hold_full;
  logic [DATA_W-1:0] hold_word;
  logic [DATA_W-1:0] active;
  logic [I1_W-1:0]   i1;
  logic [I2_W-1:0]   i2;

  logic              xfer;
  logic              accept;
  logic              hold_full_nxt;
  logic [DATA_W:0]   x;
  logic [DATA_W:0]   fb;
  logic [S1_W-1:0]   sum1;
  logic [S2_W-1:0]   sum2;
  logic [I1_W-1:0]   i1_nxt;
  logic [I2_W-1:0]   i2_nxt;

  always_comb begin
    xfer   = (cnt == CNT_W'(OSR - 1));
    accept = sif.data_valid & sif.data_ready;

    // An accept can only happen while hold is empty, so it never collides with a hold->active move.
    hold_full_nxt = hold_full;
    if (accept) begin
      hold_full_nxt = 1'b1;
    end else if (xfer) begin
      hold_full_nxt = 1'b0;
    end

    x  = {1'b0, active} - HALF;
    fb = bit_out ? HALF : NEG_HALF;

    sum1 = {{(S1_W - I1_W){i1[I1_W-1]}}, i1}
         + {{(S1_W - DATA_W - 1){x[DATA_W]}}, x}
         - {{(S1_W - DATA_W - 1){fb[DATA_W]}}, fb};
    if ((&sum1[S1_W-1:I1_W-1]) | ~(|sum1[S1_W-1:I1_W-1])) begin
      i1_nxt = sum1[I1_W-1:0];
    end else begin
      i1_nxt = sum1[S1_W-1] ? {1'b1, {(I1_W-1){1'b0}}} : {1'b0, {(I1_W-1){1'b1}}};
    end

    // Second integrator sees the freshly updated first integrator (delay-free path).
    sum2 = {{(S2_W - I2_W){i2[I2_W-1]}}, i2}
         + {{(S2_W - I1_W){i1_nxt[I1_W-1]}}, i1_nxt}
         - {{(S2_W - DATA_W - 1){fb[DATA_W]}}, fb};
    if ((&sum2[S2_W-1:I2_W-1]) | ~(|sum2[S2_W-1:I2_W-1])) begin
      i2_nxt = sum2[I2_W-1:0];
    end else begin
      i2_nxt = sum2[S2_W-1] ? {1'b1, {(I2_W-1){1'b0}}} : {1'b0, {(I2_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      hold_full      <= 1'b0;
      hold_word      <= '0;
      active         <= MID;
      i1             <= '0;
      i2             <= '0;
      bit_out        <= 1'b0;
      frame_start    <= 1'b0;
      underrun       <= 1'b0;
      sif.data_ready <= 1'b0;
    end else begin
      cnt            <= xfer ? '0 : cnt + 1'b1;
      frame_start    <= xfer;
      hold_full      <= hold_full_nxt;
      sif.data_ready <= ~hold_full_nxt;
      if (accept) begin
        hold_word <= sif.data_in;
      end
      if (xfer && hold_full) begin
        active <= hold_word;
      end
      if (xfer && !hold_full) begin
        underrun <= 1'b1;
      end
      i1      <= i1_nxt;
      i2      <= i2_nxt;
      bit_out <= ~i2_nxt[I2_W-1];
    end
  end
endmodule

// File: tb/tb_dsm_bitstream_gen.sv
// Bench for dsm_bitstream_gen: frame-level model of handshake/counter, per-frame ones-density scoreboard.
module tb_dsm_bitstream_gen;
  localparam int DATA_W = 12;
  localparam int OSR    = 512;
  localparam int TOL    = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsm_bitstream_gen_if #(.DATA_W(DATA_W)) dif ();
  logic bit_out;
  logic frame_start;
  logic underrun;

  dsm_bitstream_gen #(
    .DATA_W(DATA_W), .OSR(OSR), .I1_W(16), .I2_W(18)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sif         (dif.slave),
    .bit_out     (bit_out),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input int exp, input int tol = 0);
    n_cmp++;
    if ($isunknown(got) || int'(got) > exp + tol || int'(got) < exp - tol) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", tag, got, exp, tol, $time);
    end
  endtask

  // model of frame counter and holding register, updated on each rising edge
  int                m_cnt       = 0;
  bit                m_hold_full = 1'b0;
  bit                m_ready     = 1'b0;
  bit                m_underrun  = 1'b0;
  bit                m_fs        = 1'b0;
  bit                m_rst       = 1'b0;
  bit                m_started   = 1'b0;
  logic [DATA_W-1:0] m_hold      = '0;
  logic [DATA_W-1:0] m_active    = DATA_W'(2048);
  bit                m_acc;
  bit                m_xfer;
  logic [DATA_W-1:0] exp_q[$];

  initial begin
    forever begin
      @(posedge clk);
      m_started = 1'b1;
      m_rst     = rst;
      if (rst) begin
        m_cnt       = 0;
        m_hold_full = 1'b0;
        m_ready     = 1'b0;
        m_underrun  = 1'b0;
        m_fs        = 1'b0;
        m_active    = DATA_W'(2048);
        exp_q.delete();
        exp_q.push_back(DATA_W'(2048 / 8));
      end else begin
        m_acc  = dif.data_valid && m_ready;
        m_xfer = (m_cnt == OSR - 1);
        m_fs   = m_xfer;
        m_cnt  = m_xfer ? 0 : m_cnt + 1;
        if (m_xfer) begin
          if (m_hold_full) begin
            m_active    = m_hold;
            m_hold_full = 1'b0;
          end else begin
            m_underrun = 1'b1;
          end
          // a frame's ones count is word * OSR / 2^DATA_W = word / 8
          exp_q.push_back(m_active / 8);
        end
        if (m_acc) begin
          m_hold      = dif.data_in;
          m_hold_full = 1'b1;
        end
        m_ready = !m_hold_full;
      end
    end
  end

  // scoreboard / monitor, sampled on the falling edge
  int ones     = 0;
  bit in_frame = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        check("data_ready", {31'd0, dif.data_ready}, int'(m_ready));
        check("frame_start", {31'd0, frame_start}, int'(m_fs));
        check("underrun", {31'd0, underrun}, int'(m_underrun));
        if (m_rst) begin
          check("rst_bit_out", {31'd0, bit_out}, 0);
          in_frame = 1'b0;
          ones     = 0;
        end else begin
          if (m_cnt == 0 && in_frame) begin
            if (exp_q.size() == 0) begin
              check("exp_q_empty", 32'd0, 1);
            end else begin
              check("density", 32'(ones), int'(exp_q.pop_front()), TOL);
            end
            ones = 0;
          end
          in_frame = 1'b1;
          ones     = ones + int'(bit_out);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    dif.data_valid = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int seen = 0;
    for (int i = 0; i < (n + 1) * OSR && seen < n; i++) begin
      tick();
      if (m_fs) seen++;
    end
    if (seen < n) check("frame_timeout", 32'(seen), n);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    for (int i = 0; i < 2 * OSR && !m_ready; i++) tick();
    if (!m_ready) begin
      check("ready_timeout", 32'd0, 1);
    end else begin
      dif.data_in    = w;
      dif.data_valid = 1'b1;
      tick();
      dif.data_valid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.data_in    = '0;
    dif.data_valid = 1'b0;

    // idle after reset: mid-scale density, underrun after first boundary
    do_reset(3);
    tick();
    check("ready_cycle1", {31'd0, dif.data_ready}, 1);
    wait_frames(1);
    check("underrun_first", {31'd0, underrun}, 1);
    wait_frames(2);

    // single word before the first boundary, restarted mid-frame
    repeat ($urandom_range(50, 300)) tick();
    do_reset(2);
    send_word(DATA_W'(3072));
    tick();
    check("ready_low_full", {31'd0, dif.data_ready}, 0);
    wait_frames(1);
    check("underrun_served", {31'd0, underrun}, 0);
    tick();
    check("ready_back", {31'd0, dif.data_ready}, 1);
    wait_frames(2);

    // alternating near-bound words, one per frame
    repeat ($urandom_range(50, 300)) tick();
    do_reset(2);
    for (int f = 0; f < 6; f++) begin
      send_word((f % 2 == 0) ? DATA_W'(12'h100) : DATA_W'(12'hF00));
    end
    wait_frames(2);

    // data_valid held high with a changing word every cycle
    repeat ($urandom_range(50, 300)) tick();
    do_reset(2);
    dif.data_valid = 1'b1;
    for (int i = 0; i < 4 * OSR; i++) begin
      dif.data_in = DATA_W'($urandom_range(512, 3584));
      tick();
    end
    dif.data_valid = 1'b0;
    wait_frames(2);

    // word offered in the cnt==OSR-1 cycle lands in hold, used one frame later
    do_reset(2);
    for (int i = 0; i < 2 * OSR && m_cnt != OSR - 1; i++) tick();
    check("reach_last_cnt", 32'(m_cnt), OSR - 1);
    dif.data_in    = DATA_W'(3584);
    dif.data_valid = 1'b1;
    tick();
    dif.data_valid = 1'b0;
    check("late_ready_low", {31'd0, dif.data_ready}, 0);
    check("late_underrun", {31'd0, underrun}, 1);
    check("late_frame_start", {31'd0, frame_start}, 1);
    wait_frames(3);

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
